// File: rtl/conv2d_ctrl_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_ctrl_fetch_pkg
//  Brief    : Register map, bit positions, FSM states and kernel-count helper
//             shared by the conv2d control fetch block and its memory model.
//  Revision : 1.0  initial release
// ============================================================================
package conv2d_ctrl_fetch_pkg;

  // Control memory word addresses (word 1 is reserved and never read)
  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_GEOM   = 4'd2;
  localparam logic [3:0] ADDR_CH     = 4'd3;
  localparam logic [3:0] ADDR_KERN0  = 4'd4;

  // Status word bit positions
  localparam int ST_START_BIT   = 0;
  localparam int ST_DONE_BIT    = 1;
  localparam int ST_CONV_BIT    = 2;
  localparam int ST_BNRELU_BIT  = 3;
  localparam int ST_MAXPOOL_BIT = 4;
  localparam int ST_LAYER_LSB   = 5;

  // Geometry word bit positions
  localparam int GEOM_WIDTH_LSB  = 0;
  localparam int GEOM_HEIGHT_LSB = 8;
  localparam int GEOM_KSIZE_LSB  = 16;
  localparam int GEOM_PAD_BIT    = 18;
  localparam int GEOM_STRIDE_LSB = 19;

  // Channel word bit positions
  localparam int CH_IN_LSB  = 0;
  localparam int CH_OUT_LSB = 10;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ACK     = 3'd2,
    ST_START   = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE_WR = 3'd5,
    ST_GUARD   = 3'd6
  } state_t;

  // Number of kernel words to fetch: side 0 behaves as side 1, and the
  // count never exceeds the bank capacity.
  function automatic logic [3:0] kern_count(input logic [1:0] ksize, input int max_k);
    int side;
    int n;
    side = (ksize == 2'd0) ? 1 : int'(ksize);
    n    = side * side;
    if (n > max_k * max_k) n = max_k * max_k;
    return 4'(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv2d_ctrl_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_ctrl_fetch_if
//  Brief    : Control memory port: address, 1-cycle-latency read data and a
//             status-word write strobe with its data.
//  Revision : 1.0  initial release
// ============================================================================
interface conv2d_ctrl_fetch_if;
  logic [3:0]  o_ctrl_addr;
  logic [31:0] i_ctrl_data;
  logic        o_ctrl_we;
  logic [31:0] o_ctrl_data;

  modport master (output o_ctrl_addr, output o_ctrl_we, output o_ctrl_data, input i_ctrl_data);
  modport slave  (input o_ctrl_addr, input o_ctrl_we, input o_ctrl_data, output i_ctrl_data);
endinterface
`default_nettype wire

// File: rtl/conv2d_kernel_bank.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_kernel_bank
//  Brief    : SLOTS x DATA_WIDTH kernel register file with whole-bank clear,
//             single indexed write port and a flat read-out bus.
//  Revision : 1.0  initial release
// ============================================================================
module conv2d_kernel_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOTS      = 9,
  parameter int IDX_W      = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_we,
  input  logic [IDX_W-1:0]            i_idx,
  input  logic [DATA_WIDTH-1:0]       i_data,
  output logic [SLOTS*DATA_WIDTH-1:0] o_kernel
);

  genvar s;
  generate
    for (s = 0; s < SLOTS; s++) begin : g_slot
      logic [DATA_WIDTH-1:0] r_slot;

      // Slot register: cleared by reset or a new fetch, loaded when addressed
      always_ff @(posedge i_clk) begin
        if (!i_rst || i_clear) begin
          r_slot <= '0;
        end else if (i_we && (i_idx == IDX_W'(s))) begin
          r_slot <= i_data;
        end
      end

      assign o_kernel[s*DATA_WIDTH +: DATA_WIDTH] = r_slot;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/conv2d_ctrl_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_ctrl_fetch
//  Brief    : Polls the conv2d status word for a start request, burst-reads
//             geometry/channel/kernel words into registered configuration,
//             acknowledges, pulses the engine start and writes done back.
//  Revision : 1.0  initial release
// ============================================================================
module conv2d_ctrl_fetch
  import conv2d_ctrl_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_K      = 3
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  conv2d_ctrl_fetch_if.master               ctrl,
  output logic [7:0]                        o_width,
  output logic [7:0]                        o_height,
  output logic [1:0]                        o_ksize,
  output logic                              o_padding,
  output logic [1:0]                        o_stride,
  output logic [9:0]                        o_in_ch,
  output logic [9:0]                        o_out_ch,
  output logic                              o_op_conv,
  output logic                              o_op_bnrelu,
  output logic                              o_op_maxpool,
  output logic [3:0]                        o_layer,
  output logic [MAX_K*MAX_K*DATA_WIDTH-1:0] o_kernel,
  output logic                              o_start,
  input  logic                              i_done,
  output logic                              o_busy
);

  localparam int SLOTS = MAX_K * MAX_K;
  localparam int CNT_W = 4;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_kern_n;
  logic [CNT_W-1:0]  w_kern_idx;
  logic [31:0]       r_status;
  logic [31:0]       w_status_clr;
  logic [7:0]        r_width;
  logic [7:0]        r_height;
  logic [1:0]        r_ksize;
  logic              r_padding;
  logic [1:0]        r_stride;
  logic [9:0]        r_in_ch;
  logic [9:0]        r_out_ch;
  logic              w_start_req;
  logic              w_kern_clear;
  logic              w_kern_we;

  // A start request is only honoured with done clear; gating with reset keeps
  // the address output at zero while reset is held.
  assign w_start_req = i_rst && ctrl.i_ctrl_data[ST_START_BIT] && !ctrl.i_ctrl_data[ST_DONE_BIT];
  assign w_kern_n    = kern_count(r_ksize, MAX_K);

  // FETCH issues addr 3+cnt, so the word arriving while cnt=k is kernel slot
  // k-2; the ACK cycle receives the final slot with cnt already at N+1.
  assign w_kern_idx   = r_cnt - CNT_W'(2);
  assign w_kern_clear = (r_state == ST_IDLE) && w_start_req;
  assign w_kern_we    = ((r_state == ST_FETCH) && (r_cnt >= CNT_W'(2))) || (r_state == ST_ACK);

  // Status write-back image: latched word with start and done cleared
  always_comb begin
    w_status_clr               = r_status;
    w_status_clr[ST_START_BIT] = 1'b0;
    w_status_clr[ST_DONE_BIT]  = 1'b0;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and memory-port/start outputs
  always_comb begin
    w_state_next     = r_state;
    ctrl.o_ctrl_addr = ADDR_STATUS;
    ctrl.o_ctrl_we   = 1'b0;
    ctrl.o_ctrl_data = '0;
    o_start          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_req) begin
          w_state_next     = ST_FETCH;
          ctrl.o_ctrl_addr = ADDR_GEOM;
        end
      end
      ST_FETCH: begin
        ctrl.o_ctrl_addr = ADDR_CH + r_cnt;
        // cnt==0 never matches (N>=1), so a stale ksize cannot end the burst
        if (r_cnt == w_kern_n) w_state_next = ST_ACK;
      end
      ST_ACK: begin
        ctrl.o_ctrl_we   = 1'b1;
        ctrl.o_ctrl_data = w_status_clr;
        w_state_next     = ST_START;
      end
      ST_START: begin
        o_start      = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_done) w_state_next = ST_DONE_WR;
      end
      ST_DONE_WR: begin
        ctrl.o_ctrl_we                = 1'b1;
        ctrl.o_ctrl_data              = w_status_clr;
        ctrl.o_ctrl_data[ST_DONE_BIT] = 1'b1;
        w_state_next                  = ST_GUARD;
      end
      ST_GUARD: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Fetch word counter: held at zero outside FETCH
  always_ff @(posedge i_clk) begin
    if (!i_rst || (r_state == ST_IDLE)) begin
      r_cnt <= '0;
    end else if (r_state == ST_FETCH) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Configuration capture: status at the start sample, geometry and channels
  // one cycle after their address was issued
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_status  <= '0;
      r_width   <= '0;
      r_height  <= '0;
      r_ksize   <= '0;
      r_padding <= 1'b0;
      r_stride  <= '0;
      r_in_ch   <= '0;
      r_out_ch  <= '0;
    end else if ((r_state == ST_IDLE) && w_start_req) begin
      r_status <= ctrl.i_ctrl_data;
    end else if ((r_state == ST_FETCH) && (r_cnt == CNT_W'(0))) begin
      r_width   <= ctrl.i_ctrl_data[GEOM_WIDTH_LSB  +: 8];
      r_height  <= ctrl.i_ctrl_data[GEOM_HEIGHT_LSB +: 8];
      r_ksize   <= ctrl.i_ctrl_data[GEOM_KSIZE_LSB  +: 2];
      r_padding <= ctrl.i_ctrl_data[GEOM_PAD_BIT];
      r_stride  <= ctrl.i_ctrl_data[GEOM_STRIDE_LSB +: 2];
    end else if ((r_state == ST_FETCH) && (r_cnt == CNT_W'(1))) begin
      r_in_ch  <= ctrl.i_ctrl_data[CH_IN_LSB  +: 10];
      r_out_ch <= ctrl.i_ctrl_data[CH_OUT_LSB +: 10];
    end
  end

  conv2d_kernel_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLOTS      (SLOTS),
    .IDX_W      (CNT_W)
  ) u_kernel_bank (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_kern_clear),
    .i_we     (w_kern_we),
    .i_idx    (w_kern_idx),
    .i_data   (ctrl.i_ctrl_data[DATA_WIDTH-1:0]),
    .o_kernel (o_kernel)
  );

  assign o_width      = r_width;
  assign o_height     = r_height;
  assign o_ksize      = r_ksize;
  assign o_padding    = r_padding;
  assign o_stride     = r_stride;
  assign o_in_ch      = r_in_ch;
  assign o_out_ch     = r_out_ch;
  assign o_op_conv    = r_status[ST_CONV_BIT];
  assign o_op_bnrelu  = r_status[ST_BNRELU_BIT];
  assign o_op_maxpool = r_status[ST_MAXPOOL_BIT];
  assign o_layer      = r_status[ST_LAYER_LSB +: 4];
  assign o_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv2d_ctrl_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_conv2d_ctrl_fetch
//  Brief    : Scoreboard bench for conv2d_ctrl_fetch with a control memory
//             model, directed scenarios and randomized jobs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv2d_ctrl_fetch;

  localparam int DW    = 16;
  localparam int MK    = 3;
  localparam int SLOTS = MK * MK;

  logic clk = 1'b0;
  logic rst_n;
  logic i_done;
  logic [7:0] o_width, o_height;
  logic [1:0] o_ksize, o_stride;
  logic       o_padding, o_op_conv, o_op_bnrelu, o_op_maxpool, o_start, o_busy;
  logic [9:0] o_in_ch, o_out_ch;
  logic [3:0] o_layer;
  logic [SLOTS*DW-1:0] o_kernel;

  conv2d_ctrl_fetch_if ctrl ();

  conv2d_ctrl_fetch #(.DATA_WIDTH(DW), .MAX_K(MK)) dut (
    .i_clk(clk), .i_rst(rst_n), .ctrl(ctrl),
    .o_width(o_width), .o_height(o_height), .o_ksize(o_ksize), .o_padding(o_padding),
    .o_stride(o_stride), .o_in_ch(o_in_ch), .o_out_ch(o_out_ch), .o_op_conv(o_op_conv),
    .o_op_bnrelu(o_op_bnrelu), .o_op_maxpool(o_op_maxpool), .o_layer(o_layer),
    .o_kernel(o_kernel), .o_start(o_start), .i_done(i_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mem [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Control memory: registered read of last cycle's address, status writes
  always @(posedge clk) begin
    ctrl.i_ctrl_data <= mem[ctrl.o_ctrl_addr];
    if (ctrl.o_ctrl_we) mem[ctrl.o_ctrl_addr] = ctrl.o_ctrl_data;
  end

  typedef struct {
    bit          is_start;
    int          cyc;
    logic [31:0] data;
    logic [191:0] cfg;
  } exp_t;
  exp_t exp_q[$];

  logic [191:0] act_cfg;
  logic [230:0] all_out;
  assign act_cfg = {o_width, o_height, o_ksize, o_padding, o_stride, o_in_ch, o_out_ch,
                    o_op_conv, o_op_bnrelu, o_op_maxpool, o_layer, o_kernel};
  assign all_out = {ctrl.o_ctrl_addr, ctrl.o_ctrl_we, ctrl.o_ctrl_data, o_start, o_busy, act_cfg};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Reference model: kernel word count from the kernel side
  function automatic int model_n(input logic [1:0] k);
    int side;
    int n;
    side = (k == 2'd0) ? 1 : int'(k);
    n = side * side;
    if (n > SLOTS) n = SLOTS;
    return n;
  endfunction

  // Reference model: decoded configuration straight from the register map
  function automatic logic [191:0] model_cfg(input logic [31:0] w0, w2, w3, input int n);
    logic [SLOTS*DW-1:0] kern;
    kern = '0;
    for (int j = 0; j < SLOTS; j++)
      if (j < n) kern[j*DW +: DW] = mem[4+j][DW-1:0];
    return {w2[7:0], w2[15:8], w2[17:16], w2[18], w2[20:19], w3[9:0], w3[19:10],
            w0[2], w0[3], w0[4], w0[8:5], kern};
  endfunction

  // Monitor: every write strobe or start pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (ctrl.o_ctrl_we === 1'b1 || o_start === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: we=%0b start=%0b data=%0h expected none (cycle %0d)",
                 ctrl.o_ctrl_we, o_start, ctrl.o_ctrl_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (o_start) begin
          if (!e.is_start || e.cyc != cyc || act_cfg !== e.cfg) begin
            n_err++;
            $display("FAIL start_cfg: got cycle %0d cfg %0h expected start=%0b cycle %0d cfg %0h",
                     cyc, act_cfg, e.is_start, e.cyc, e.cfg);
          end
        end else begin
          if (e.is_start || e.cyc != cyc || ctrl.o_ctrl_data !== e.data || ctrl.o_ctrl_addr !== 4'd0) begin
            n_err++;
            $display("FAIL status_write: got cycle %0d addr %0h data %0h expected write=%0b cycle %0d addr 0 data %0h",
                     cyc, ctrl.o_ctrl_addr, ctrl.o_ctrl_data, !e.is_start, e.cyc, e.data);
          end
        end
      end
    end
  end

  // One complete job: arm status at the next cycle, check fetch addresses,
  // then complete the engine run either after a delay or with done held early
  task automatic run_job(input logic [31:0] w0, w2, w3, input int delay, input bit early);
    int s, n, d;
    exp_t e;
    logic [31:0] ack;
    logic [3:0] ea;
    s = cyc + 1;
    mem[2] = w2;
    mem[3] = w3;
    mem[0] = w0;
    n   = model_n(w2[17:16]);
    ack = w0 & ~32'h3;
    e = '{is_start: 1'b0, cyc: s + n + 2, data: ack, cfg: '0};
    exp_q.push_back(e);
    e = '{is_start: 1'b1, cyc: s + n + 3, data: '0, cfg: model_cfg(w0, w2, w3, n)};
    exp_q.push_back(e);
    for (int c = s; c <= s + n + 1; c++) begin
      wait_until(c);
      ea = (c == s) ? 4'd2 : (c == s + 1) ? 4'd3 : 4'(4 + c - s - 2);
      check("fetch_addr", ctrl.o_ctrl_addr, ea);
      if (c == s)     check("busy_at_S", o_busy, 1'b0);
      if (c == s + 1) check("busy_at_S1", o_busy, 1'b1);
      if (c == s + 2) check("geom_at_S2", {o_width, o_height}, {w2[7:0], w2[15:8]});
    end
    if (early) begin
      wait_until(s + n + 3);
      i_done = 1'b1;
      d = s + n + 4;
    end else begin
      d = s + n + 3 + delay;
      wait_until(d);
      i_done = 1'b1;
    end
    e = '{is_start: 1'b0, cyc: d + 1, data: ack | 32'h2, cfg: '0};
    exp_q.push_back(e);
    wait_until(d + 1);
    i_done = 1'b0;
    wait_until(d + 2);
    check("busy_guard", o_busy, 1'b1);
    wait_until(d + 3);
    check("busy_fall", o_busy, 1'b0);
    check("idle_addr", ctrl.o_ctrl_addr, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    logic [31:0] w0;
    logic [15:0] kdir [9] = '{16'h0100, 16'h0080, 16'h0100, 16'hFF00, 16'hFF80,
                               16'h0100, 16'h0100, 16'h0100, 16'h0080};
    rst_n  = 1'b0;
    i_done = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs_set_bits", $countones(all_out), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_poll_addr", ctrl.o_ctrl_addr, 4'd0);
    check("idle_busy", o_busy, 1'b0);

    // Directed 3x3 job, then a 1x1 job on top of it
    for (int j = 0; j < 9; j++) mem[4+j] = {16'h0, kdir[j]};
    run_job(32'h05, 32'h000F0606, 32'h4003, 20, 1'b0);
    run_job(32'h05, 32'h000D0606, 32'h4003, 5, 1'b0);

    // Start with done still set must be ignored
    mem[0] = 32'h07;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("start_with_done_busy", o_busy, 1'b0);
    end
    mem[0] = 32'h0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a fetch aborts with no write-back
    s = cyc + 1;
    mem[2] = 32'h000F0606;
    mem[0] = 32'h05;
    wait_until(s + 5);
    rst_n  = 1'b0;
    mem[0] = 32'h0;
    wait_until(s + 6);
    check("abort_outputs_set_bits", $countones(all_out), 0);
    wait_until(s + 7);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_job(32'h05, 32'h000F0606, 32'h4003, 7, 1'b0);

    // Done held high through START into RUN
    run_job(32'h05, 32'h000F0606, 32'h4003, 0, 1'b1);

    // Randomized jobs
    for (int r = 0; r < 8; r++) begin
      for (int j = 4; j < 13; j++) mem[j] = $urandom;
      mem[1] = $urandom;
      w0 = $urandom;
      w0[0] = 1'b1;
      w0[1] = 1'b0;
      run_job(w0, $urandom, $urandom, int'($urandom_range(1, 12)), (r % 3) == 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
